// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state codes and default bit timing.
package uart_rx_pkg;

  // Codes mirror the transmitter encoding so state dumps read the same on both sides.
  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    START     = 3'b001,
    DATA      = 3'b011,
    STOP      = 3'b010,
    DONE      = 3'b110,
    ERR       = 3'b111,
    WAIT_HIGH = 3'b101
  } rx_state_t;

  // 100 MHz system clock at 9600 baud.
  localparam int unsigned DEFAULT_CLK_DIVIDER   = 10417;
  localparam int unsigned DEFAULT_NBITS_DIVIDER = 14;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; reset value is chosen per use
// so idle-high lines do not look like activity right after reset.
module sync_2ff #(
  parameter int unsigned          WIDTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // Next values: first stage captures the raw input, second stage resolves metastability.
  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  // Synchronizer flops.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, idle-high line. Mid-bit sampling driven by a
// clock-divider bit timer; one-cycle strobes for a good byte or a framing error.
//
// state     | meaning
// IDLE      | line idle, waiting for a low level
// START     | half-bit wait, then confirm start bit (high = glitch)
// DATA      | sample 8 data bits at bit centres, LSB first
// STOP      | sample stop bit at its centre
// DONE      | one cycle: publish byte, pulse o_valid
// ERR       | one cycle: pulse o_frameErr, byte discarded
// WAIT_HIGH | hold off until the line returns high (break / stuck low)
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_DIVIDER   = DEFAULT_CLK_DIVIDER,
  parameter int unsigned NBITS_DIVIDER = DEFAULT_NBITS_DIVIDER
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_serialRX,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frameErr,
  output logic       o_busy
);

  localparam logic [NBITS_DIVIDER-1:0] HALF_LAST = NBITS_DIVIDER'(CLK_DIVIDER / 2 - 1);
  localparam logic [NBITS_DIVIDER-1:0] FULL_LAST = NBITS_DIVIDER'(CLK_DIVIDER - 1);
  localparam logic [NBITS_DIVIDER-1:0] CNT_ONE   = NBITS_DIVIDER'(1);

  rx_state_t                state_q, state_d;
  logic [NBITS_DIVIDER-1:0] cnt_q, cnt_d;
  logic [2:0]               idx_q, idx_d;
  logic [7:0]               shift_q, shift_d;
  logic [7:0]               data_q, data_d;
  logic                     rx_s;
  logic                     half_tick;
  logic                     full_tick;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync_rx (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_serialRX),
    .o_q   (rx_s)
  );

  assign half_tick = (cnt_q == HALF_LAST);
  assign full_tick = (cnt_q == FULL_LAST);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!rx_s) state_d = START;
      START:     if (half_tick) state_d = rx_s ? IDLE : DATA;
      DATA:      if (full_tick && (idx_q == 3'd7)) state_d = STOP;
      STOP:      if (full_tick) state_d = rx_s ? DONE : ERR;
      DONE:      state_d = IDLE;
      ERR:       state_d = WAIT_HIGH;
      WAIT_HIGH: if (rx_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath: bit timer, bit index, shift register and output byte.
  always_comb begin
    cnt_d   = '0;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    case (state_q)
      IDLE: idx_d = 3'd0;
      START: cnt_d = half_tick ? '0 : cnt_q + CNT_ONE;
      DATA: begin
        cnt_d = full_tick ? '0 : cnt_q + CNT_ONE;
        if (full_tick) begin
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
        end
      end
      STOP: begin
        cnt_d = full_tick ? '0 : cnt_q + CNT_ONE;
        // Load on the good stop sample so o_data is already new while o_valid is high.
        if (full_tick && rx_s) data_d = shift_q;
      end
      default: cnt_d = '0;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
    end
  end

  assign o_data     = data_q;
  assign o_valid    = (state_q == DONE);
  assign o_frameErr = (state_q == ERR);
  assign o_busy     = (state_q == DATA) || (state_q == STOP);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLK_DIVIDER=16: table of single frames plus
// hand-written sequences for back-to-back, glitch, reset, loopback and skew.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int DIV    = 16;
  localparam int CLK_NS = 10;
  localparam int BIT_NS = DIV * CLK_NS;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_serialRX = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frameErr;
  logic       o_busy;

  uart_rx #(.CLK_DIVIDER(DIV), .NBITS_DIVIDER(5)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_serialRX (i_serialRX),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_frameErr (o_frameErr),
    .o_busy     (o_busy)
  );

  always #(CLK_NS / 2) i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  // Output monitor, sampled on the falling edge.
  int         valid_cnt   = 0;
  int         err_cnt     = 0;
  int         busy_cycles = 0;
  int         overlap_cnt = 0;
  logic [7:0] data_log [0:1023];

  always @(negedge i_clk) begin
    if (o_valid) begin
      if (valid_cnt < 1024) data_log[valid_cnt] = o_data;
      valid_cnt++;
    end
    if (o_frameErr) err_cnt++;
    if (o_busy) busy_cycles++;
    if (o_valid && o_frameErr) overlap_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    @(negedge i_clk);
  endtask

  // Behavioural transmitter: start, 8 data bits LSB first, stop. A bad stop bit
  // keeps the line low for a further 40 cycles before releasing it.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int bit_ns);
    i_serialRX = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      i_serialRX = d[i];
      #(bit_ns);
    end
    i_serialRX = stop_ok;
    #(bit_ns);
    if (!stop_ok) begin
      #(40 * CLK_NS);
      i_serialRX = 1'b1;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    logic [7:0] exp_data;
    int         exp_valid;
    int         exp_err;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] exp_lb [256];
  int         v0, e0, b0;
  logic [7:0] b;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
    vecs[1] = '{8'h3C, 1'b0, 8'hA5, 0, 1};
    vecs[2] = '{8'h81, 1'b1, 8'h81, 1, 0};
    vecs[3] = '{8'h01, 1'b1, 8'h01, 1, 0};
    vecs[4] = '{8'h80, 1'b1, 8'h80, 1, 0};
    vecs[5] = '{8'hE7, 1'b0, 8'h80, 0, 1};

    // Reset with line high.
    idle(3);
    check("rst o_data", o_data, 8'h00);
    check("rst o_valid", o_valid, 0);
    check("rst o_frameErr", o_frameErr, 0);
    check("rst o_busy", o_busy, 0);
    i_rst = 1'b1;
    idle(200);
    check("rst no valid 200", valid_cnt, 0);
    check("rst no err 200", err_cnt, 0);
    check("rst no busy 200", busy_cycles, 0);

    // Table of single frames.
    for (int k = 0; k < 6; k++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      send_frame(vecs[k].data, vecs[k].stop_ok, BIT_NS);
      idle(2 * DIV);
      check($sformatf("vec%0d valid pulses", k), valid_cnt - v0, vecs[k].exp_valid);
      check($sformatf("vec%0d err pulses", k), err_cnt - e0, vecs[k].exp_err);
      check($sformatf("vec%0d o_data", k), o_data, vecs[k].exp_data);
      check($sformatf("vec%0d o_busy after", k), o_busy, 0);
    end

    // Back-to-back frames with a single stop bit between them.
    v0 = valid_cnt;
    send_frame(8'h00, 1'b1, BIT_NS);
    send_frame(8'hFF, 1'b1, BIT_NS);
    send_frame(8'h5A, 1'b1, BIT_NS);
    idle(2 * DIV);
    check("b2b valid pulses", valid_cnt - v0, 3);
    check("b2b byte0", data_log[v0], 8'h00);
    check("b2b byte1", data_log[v0 + 1], 8'hFF);
    check("b2b byte2", data_log[v0 + 2], 8'h5A);

    // Start glitch shorter than half a bit.
    v0 = valid_cnt;
    e0 = err_cnt;
    b0 = busy_cycles;
    i_serialRX = 1'b0;
    repeat (5) @(negedge i_clk);
    i_serialRX = 1'b1;
    idle(40);
    check("glitch busy", busy_cycles - b0, 0);
    check("glitch valid", valid_cnt - v0, 0);
    check("glitch err", err_cnt - e0, 0);
    check("glitch state", 32'(dut.state_q), 32'(IDLE));

    // Reset in the middle of the data bits of 8'hC3, then a clean 8'h96.
    v0 = valid_cnt;
    e0 = err_cnt;
    b = 8'hC3;
    i_serialRX = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      i_serialRX = b[i];
      #(BIT_NS);
    end
    check("midrst busy before", o_busy, 1);
    i_rst = 1'b0;
    #1;
    check("midrst busy in reset", o_busy, 0);
    check("midrst o_data in reset", o_data, 8'h00);
    i_serialRX = 1'b1;
    idle(3);
    i_rst = 1'b1;
    idle(40);
    send_frame(8'h96, 1'b1, BIT_NS);
    idle(2 * DIV);
    check("midrst valid pulses", valid_cnt - v0, 1);
    check("midrst err pulses", err_cnt - e0, 0);
    check("midrst o_data", o_data, 8'h96);

    // Loopback of 256 random bytes at nominal baud, back to back.
    v0 = valid_cnt;
    for (int k = 0; k < 256; k++) begin
      exp_lb[k] = 8'($urandom);
      send_frame(exp_lb[k], 1'b1, BIT_NS);
    end
    idle(2 * DIV);
    check("loop valid pulses", valid_cnt - v0, 256);
    for (int k = 0; k < 256; k++)
      check($sformatf("loop byte%0d", k), data_log[v0 + k], exp_lb[k]);

    // About 3% fast and slow transmitter, with an idle gap between frames.
    for (int s = 0; s < 2; s++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      for (int k = 0; k < 16; k++) begin
        exp_lb[k] = 8'($urandom);
        #2;
        send_frame(exp_lb[k], 1'b1, (s == 0) ? 155 : 165);
        idle(2 * DIV);
      end
      check($sformatf("skew%0d valid pulses", s), valid_cnt - v0, 16);
      check($sformatf("skew%0d err pulses", s), err_cnt - e0, 0);
      for (int k = 0; k < 16; k++)
        check($sformatf("skew%0d byte%0d", s, k), data_log[v0 + k], exp_lb[k]);
    end

    check("valid/err overlap", overlap_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
